instruction_decode: RTL and testbench

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

---
 rtl/instruction_decode.sv | 200 ++++++++++++++++++++
 tb/tb_instruction_decode.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - ID stage: register file, control decode, branch resolve, load-use stall, ID/EX register
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   instruccion, pc         instruction word and incremented PC from IF/ID
//   reg_write_wb, write_reg_wb, write_data_wb   write-back port into the register file
//   mem_read_ex, rt_ex      load currently in EX and its destination (load-use detection)
//   pc_salto, PCSrc         branch/jump target and its select for the fetch mux
//   pc_write, if_id_write   fetch enables, dropped for one cycle on a load-use stall
//   if_flush                squashes the IF/ID register when a branch/jump is taken
//   read_data_1/2, inm_ext, rs, rt, rd, pc_ex, control bits   registered ID/EX outputs

module instruction_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruccion,
    input  logic [10:0] pc,
    input  logic        reg_write_wb,
    input  logic [4:0]  write_reg_wb,
    input  logic [31:0] write_data_wb,
    input  logic        mem_read_ex,
    input  logic [4:0]  rt_ex,
    output logic [10:0] pc_salto,
    output logic        PCSrc,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_flush,
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    output logic [31:0] inm_ext,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [10:0] pc_ex,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_op
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [5:0]  opcode;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic        wb_en;
    logic [31:0] regs [32];
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        uses_rt;
    logic        stall;
    logic        taken;
    logic        d_reg_dst, d_alu_src, d_mem_read, d_mem_write, d_mem_to_reg, d_reg_write;
    logic [1:0]  d_alu_op;

    assign opcode = instruccion[31:26];
    assign rs_idx = instruccion[25:21];
    assign rt_idx = instruccion[20:16];
    assign rd_idx = instruccion[15:11];

    // Write-back is ignored entirely while in reset, including the bypass path.
    assign wb_en = reg_write_wb & ~reset;

    // Reads bypass a same-cycle write so the value seen here is what the
    // register file will hold after this edge; r0 is hardwired to zero.
    always_comb begin
        rd1 = regs[rs_idx];
        rd2 = regs[rt_idx];
        if (wb_en && write_reg_wb == rs_idx) rd1 = write_data_wb;
        if (wb_en && write_reg_wb == rt_idx) rd2 = write_data_wb;
        if (rs_idx == 5'd0) rd1 = '0;
        if (rt_idx == 5'd0) rd2 = '0;
    end

    always_comb begin
        d_reg_dst    = 1'b0;
        d_alu_src    = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_reg_write  = 1'b0;
        d_alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                d_reg_dst   = 1'b1;
                d_reg_write = 1'b1;
                d_alu_op    = 2'b10;
            end
            OP_LW: begin
                d_alu_src    = 1'b1;
                d_mem_read   = 1'b1;
                d_mem_to_reg = 1'b1;
                d_reg_write  = 1'b1;
            end
            OP_SW: begin
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
            end
            OP_ADDI: begin
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Only these opcodes actually consume rt as a source operand.
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ)   || (opcode == OP_BNE);

    assign stall = ~reset && mem_read_ex && (rt_ex != 5'd0) &&
                   ((rt_ex == rs_idx) || (uses_rt && rt_ex == rt_idx));

    always_comb begin
        taken    = 1'b0;
        pc_salto = '0;
        case (opcode)
            OP_BEQ: begin
                taken    = (rd1 == rd2);
                pc_salto = pc + instruccion[10:0];
            end
            OP_BNE: begin
                taken    = (rd1 != rd2);
                pc_salto = pc + instruccion[10:0];
            end
            OP_J: begin
                taken    = 1'b1;
                pc_salto = instruccion[10:0];
            end
            default: ;
        endcase
    end

    assign PCSrc       = ~reset & ~stall & taken;
    assign if_flush    = PCSrc;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (wb_en && write_reg_wb != 5'd0) begin
            regs[write_reg_wb] <= write_data_wb;
        end
    end

    // ID/EX register. A stall inserts a bubble: controls cleared, data fields held.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_1 <= '0;
            read_data_2 <= '0;
            inm_ext     <= '0;
            rs          <= '0;
            rt          <= '0;
            rd          <= '0;
            pc_ex       <= '0;
            reg_dst     <= 1'b0;
            alu_src     <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_to_reg  <= 1'b0;
            reg_write   <= 1'b0;
            alu_op      <= 2'b00;
        end else if (stall) begin
            reg_dst     <= 1'b0;
            alu_src     <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_to_reg  <= 1'b0;
            reg_write   <= 1'b0;
            alu_op      <= 2'b00;
        end else begin
            read_data_1 <= rd1;
            read_data_2 <= rd2;
            inm_ext     <= {{16{instruccion[15]}}, instruccion[15:0]};
            rs          <= rs_idx;
            rt          <= rt_idx;
            rd          <= rd_idx;
            pc_ex       <= pc;
            reg_dst     <= d_reg_dst;
            alu_src     <= d_alu_src;
            mem_read    <= d_mem_read;
            mem_write   <= d_mem_write;
            mem_to_reg  <= d_mem_to_reg;
            reg_write   <= d_reg_write;
            alu_op      <= d_alu_op;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - self-checking bench for instruction_decode

module tb_instruction_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruccion;
    logic [10:0] pc;
    logic        reg_write_wb;
    logic [4:0]  write_reg_wb;
    logic [31:0] write_data_wb;
    logic        mem_read_ex;
    logic [4:0]  rt_ex;
    logic [10:0] pc_salto;
    logic        PCSrc, pc_write, if_id_write, if_flush;
    logic [31:0] read_data_1, read_data_2, inm_ext;
    logic [4:0]  rs, rt, rd;
    logic [10:0] pc_ex;
    logic        reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic [1:0]  alu_op;

    instruction_decode dut (
        .clock(clock), .reset(reset), .instruccion(instruccion), .pc(pc),
        .reg_write_wb(reg_write_wb), .write_reg_wb(write_reg_wb), .write_data_wb(write_data_wb),
        .mem_read_ex(mem_read_ex), .rt_ex(rt_ex),
        .pc_salto(pc_salto), .PCSrc(PCSrc), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_flush(if_flush), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .inm_ext(inm_ext), .rs(rs), .rt(rt), .rd(rd), .pc_ex(pc_ex),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_op(alu_op)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register array, opcode -> control table, expected ID/EX contents.
    // Control vector order: {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op[1:0]}
    logic [7:0]  ctrl_tab [64];
    logic [31:0] m_regs [32];
    logic [7:0]  e_ctrl;
    logic [31:0] e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [10:0] e_pc;

    initial begin
        for (int i = 0; i < 64; i++) ctrl_tab[i] = 8'h00;
        ctrl_tab[6'h00] = 8'b1_0_0_0_0_1_10;
        ctrl_tab[6'h23] = 8'b0_1_1_0_1_1_00;
        ctrl_tab[6'h2B] = 8'b0_1_0_1_0_0_00;
        ctrl_tab[6'h08] = 8'b0_1_0_0_0_1_00;
    end

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (reg_write_wb && !reset && write_reg_wb == idx) return write_data_wb;
        return m_regs[idx];
    endfunction

    function automatic logic m_stall();
        logic [5:0] op;
        logic       src_rt;
        op = instruccion[31:26];
        src_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        if (reset || !mem_read_ex || rt_ex == 0) return 1'b0;
        return (rt_ex == instruccion[25:21]) || (src_rt && rt_ex == instruccion[20:16]);
    endfunction

    function automatic logic m_taken();
        logic [31:0] a, b;
        a = mread(instruccion[25:21]);
        b = mread(instruccion[20:16]);
        case (instruccion[31:26])
            6'h04:   return a == b;
            6'h05:   return a != b;
            6'h02:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [10:0] m_target();
        int t;
        case (instruccion[31:26])
            6'h04, 6'h05: begin
                t = (int'(pc) + int'(instruccion[10:0])) % 2048;
                return 11'(t);
            end
            6'h02:   return instruccion[10:0];
            default: return 11'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            e_ctrl <= 8'd0; e_rd1 <= 32'd0; e_rd2 <= 32'd0; e_imm <= 32'd0;
            e_rs <= 5'd0; e_rt <= 5'd0; e_rd <= 5'd0; e_pc <= 11'd0;
        end else begin
            if (reg_write_wb && write_reg_wb != 0) m_regs[write_reg_wb] <= write_data_wb;
            if (m_stall()) begin
                e_ctrl <= 8'd0;
            end else begin
                e_ctrl <= ctrl_tab[instruccion[31:26]];
                e_rd1  <= mread(instruccion[25:21]);
                e_rd2  <= mread(instruccion[20:16]);
                e_imm  <= 32'($signed(instruccion[15:0]));
                e_rs   <= instruccion[25:21];
                e_rt   <= instruccion[20:16];
                e_rd   <= instruccion[15:11];
                e_pc   <= pc;
            end
        end
    end

    // Compare process: every negedge once the model has been reset alongside the DUT.
    always @(negedge clock) begin
        if (model_on) begin
            logic s, br;
            s  = m_stall();
            br = !reset && !s && m_taken();
            chk("pc_write", 32'(pc_write), 32'(!s));
            chk("if_id_write", 32'(if_id_write), 32'(!s));
            chk("PCSrc", 32'(PCSrc), 32'(br));
            chk("if_flush", 32'(if_flush), 32'(br));
            if (!reset) chk("pc_salto", 32'(pc_salto), 32'(m_target()));
            chk("ctrl", 32'({reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}), 32'(e_ctrl));
            chk("read_data_1", read_data_1, e_rd1);
            chk("read_data_2", read_data_2, e_rd2);
            chk("inm_ext", inm_ext, e_imm);
            chk("rs", 32'(rs), 32'(e_rs));
            chk("rt", 32'(rt), 32'(e_rt));
            chk("rd", 32'(rd), 32'(e_rd));
            chk("pc_ex", 32'(pc_ex), 32'(e_pc));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        instruccion = 32'd0; pc = 11'd0; reg_write_wb = 1'b0; write_reg_wb = 5'd0;
        write_data_wb = 32'd0; mem_read_ex = 1'b0; rt_ex = 5'd0;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    logic [5:0] op_pool [8];

    initial begin
        op_pool = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3F};
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_ctrl", 32'({reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}), 32'd0);
        chk("reset_rd1", read_data_1, 32'd0);
        chk("reset_pc_write", 32'(pc_write), 32'd1);
        model_on = 1'b1;
        reset = 1'b0;

        // Write r5 then decode add r3,r5,r6
        reg_write_wb = 1'b1; write_reg_wb = 5'd5; write_data_wb = 32'h0000_00AA;
        tick();
        reg_write_wb = 1'b0;
        instruccion = r_type(5'd5, 5'd6, 5'd3);
        tick();
        chk("add_rd1", read_data_1, 32'h0000_00AA);
        chk("add_reg_dst", 32'(reg_dst), 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'd2);
        chk("add_reg_write", 32'(reg_write), 32'd1);
        chk("add_rd", 32'(rd), 32'd3);

        // Same-cycle bypass of r7
        reg_write_wb = 1'b1; write_reg_wb = 5'd7; write_data_wb = 32'h0000_1234;
        instruccion = r_type(5'd7, 5'd0, 5'd1);
        tick();
        reg_write_wb = 1'b0;
        chk("bypass_rd1", read_data_1, 32'h0000_1234);

        // Load-use stall then normal decode
        mem_read_ex = 1'b1; rt_ex = 5'd4; instruccion = r_type(5'd4, 5'd1, 5'd2);
        #1;
        chk("stall_pc_write", 32'(pc_write), 32'd0);
        chk("stall_if_id_write", 32'(if_id_write), 32'd0);
        tick();
        chk("bubble_ctrl", 32'({reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}), 32'd0);
        mem_read_ex = 1'b0;
        #1;
        chk("unstall_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("after_stall_reg_write", 32'(reg_write), 32'd1);
        chk("after_stall_rs", 32'(rs), 32'd4);

        // beq r1,r1 with wrap-around target; sw decode alongside checks sign extension
        instruccion = i_type(6'h04, 5'd1, 5'd1, 16'h0020); pc = 11'h7F0;
        #1;
        chk("beq_PCSrc", 32'(PCSrc), 32'd1);
        chk("beq_if_flush", 32'(if_flush), 32'd1);
        chk("beq_pc_salto", 32'(pc_salto), 32'h010);
        tick();
        chk("beq_ctrl", 32'({reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}), 32'd0);
        instruccion = i_type(6'h2B, 5'd2, 5'd3, 16'h8004);
        tick();
        chk("sw_inm_ext", inm_ext, 32'hFFFF_8004);
        chk("sw_ctrl", 32'({reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}), 32'b0_1_0_1_0_0_00);

        // r0 stays zero
        reg_write_wb = 1'b1; write_reg_wb = 5'd0; write_data_wb = 32'hFFFF_FFFF;
        instruccion = r_type(5'd0, 5'd0, 5'd1);
        tick();
        reg_write_wb = 1'b0;
        chk("r0_bypass", read_data_1, 32'd0);
        tick();
        chk("r0_read", read_data_2, 32'd0);

        // Unknown opcode is a NOP
        instruccion = {6'h3F, 26'h3FF_FFFF};
        tick();
        chk("nop_ctrl", 32'({reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}), 32'd0);

        // Reset during a stall
        instruccion = r_type(5'd4, 5'd1, 5'd2); mem_read_ex = 1'b1; rt_ex = 5'd4;
        reset = 1'b1; reg_write_wb = 1'b1; write_reg_wb = 5'd9; write_data_wb = 32'hDEAD_BEEF;
        #1;
        chk("rst_stall_pc_write", 32'(pc_write), 32'd1);
        chk("rst_stall_PCSrc", 32'(PCSrc), 32'd0);
        tick();
        chk("rst_stall_ctrl", 32'({reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}), 32'd0);
        chk("rst_stall_rd1", read_data_1, 32'd0);
        reset = 1'b0; reg_write_wb = 1'b0; mem_read_ex = 1'b0;
        instruccion = r_type(5'd9, 5'd5, 5'd3);
        tick();
        chk("post_rst_reg_write", 32'(reg_write), 32'd1);
        chk("post_rst_r9", read_data_1, 32'd0);
        chk("post_rst_r5", read_data_2, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] s, t;
            logic [5:0] op;
            op = op_pool[$urandom_range(0, 7)];
            if (op == 6'h3F) op = 6'($urandom);
            s = 5'($urandom_range(0, 7));
            t = ($urandom_range(0, 3) == 0) ? s : 5'($urandom_range(0, 7));
            instruccion   = {op, s, t, 16'($urandom)};
            pc            = 11'($urandom);
            reg_write_wb  = 1'($urandom);
            write_reg_wb  = 5'($urandom_range(0, 7));
            write_data_wb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            mem_read_ex   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0:       rt_ex = s;
                1:       rt_ex = t;
                default: rt_ex = 5'($urandom_range(0, 7));
            endcase
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
